// File: rtl/vdf_square_sched.sv
// vdf_square_sched: sequences T back-to-back modular squarings on one
// pipelined multiplier, feeding each result back as the next operand, and
// returns x^(2^T) on a valid/ready result port.
// Optional build macro VDF_SQ_SCHED_TIMEOUT_EN adds a WAIT-state watchdog
// that aborts a job after TIMEOUT cycles without a multiplier result
// (result flagged with o_err). Without the macro o_err is tied low and
// WAIT persists until the multiplier answers.
module vdf_square_sched #(
  parameter int unsigned BITS    = 256,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  // request side
  input  logic             i_val,
  output logic             o_rdy,
  input  logic [BITS-1:0]  i_dat,
  input  logic [CNT_W-1:0] i_iter,
  // result side
  output logic             o_val,
  input  logic             i_rdy,
  output logic [BITS-1:0]  o_dat,
  output logic             o_err,
  output logic [CNT_W-1:0] o_iter_cnt,
  output logic             o_busy,
  // multiplier operand side
  output logic             o_mul_val,
  input  logic             i_mul_rdy,
  output logic [BITS-1:0]  o_mul_dat_a,
  output logic [BITS-1:0]  o_mul_dat_b,
  // multiplier result side
  input  logic             i_mul_val,
  output logic             o_mul_rdy,
  input  logic [BITS-1:0]  i_mul_dat
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [BITS-1:0]  val_q;
  logic [BITS-1:0]  val_d;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

`ifdef VDF_SQ_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;
  logic             err_q;
  logic             err_d;
  logic             tmo_hit;

  // Last WAIT cycle before the watchdog fires; DONE follows TIMEOUT cycles after WAIT entry
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign o_err   = err_q;
`else
  // TIMEOUT only shapes the watchdog build; nothing is generated here
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
  assign o_err = 1'b0;
`endif

  // Operands always come straight from the value register, so A and B are identical
  assign o_mul_dat_a = val_q;
  assign o_mul_dat_b = val_q;
  assign o_iter_cnt  = cnt_q;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update decode
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
`ifdef VDF_SQ_SCHED_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_val) begin
          val_d   = i_dat;
          rem_d   = i_iter;
          cnt_d   = '0;
`ifdef VDF_SQ_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = (i_iter == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_mul_rdy) begin
          rem_d   = rem_q - CNT_W'(1);
`ifdef VDF_SQ_SCHED_TIMEOUT_EN
          tmo_d   = '0;
`endif
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mul_val) begin
          val_d   = i_mul_dat;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (rem_q == '0) ? S_DONE : S_ISSUE;
        end
`ifdef VDF_SQ_SCHED_TIMEOUT_EN
        else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
`endif
      end
      S_DONE: begin
        if (i_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath registers: running value, remaining squarings, completed squarings
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      val_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef VDF_SQ_SCHED_TIMEOUT_EN
  // Watchdog counter and abort flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`endif

  // Handshake/status outputs registered from the next state: no input-to-output path
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdy     <= 1'b1;
      o_busy    <= 1'b0;
      o_mul_val <= 1'b0;
      o_mul_rdy <= 1'b0;
      o_val     <= 1'b0;
      o_dat     <= '0;
    end else begin
      o_rdy     <= (state_d == S_IDLE);
      o_busy    <= (state_d != S_IDLE);
      o_mul_val <= (state_d == S_ISSUE);
      o_mul_rdy <= (state_d == S_WAIT);
      o_val     <= (state_d == S_DONE);
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
        o_dat <= val_d;
      end
    end
  end

endmodule

// File: tb/tb_vdf_square_sched.sv
// tb_vdf_square_sched: directed bench for the squaring scheduler with a
// modulo-251, 7-cycle-latency multiplier model.
`timescale 1ns/1ps
module tb_vdf_square_sched;

  localparam int unsigned BITS    = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int          LAT     = 7;
  localparam longint      MODV    = 251;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_val;
  logic             o_rdy;
  logic [BITS-1:0]  i_dat;
  logic [CNT_W-1:0] i_iter;
  logic             o_val;
  logic             i_rdy;
  logic [BITS-1:0]  o_dat;
  logic             o_err;
  logic [CNT_W-1:0] o_iter_cnt;
  logic             o_busy;
  logic             o_mul_val;
  logic             i_mul_rdy;
  logic [BITS-1:0]  o_mul_dat_a;
  logic [BITS-1:0]  o_mul_dat_b;
  logic             i_mul_val;
  logic             o_mul_rdy;
  logic [BITS-1:0]  i_mul_dat;

  vdf_square_sched #(
    .BITS    (BITS),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_val       (i_val),
    .o_rdy       (o_rdy),
    .i_dat       (i_dat),
    .i_iter      (i_iter),
    .o_val       (o_val),
    .i_rdy       (i_rdy),
    .o_dat       (o_dat),
    .o_err       (o_err),
    .o_iter_cnt  (o_iter_cnt),
    .o_busy      (o_busy),
    .o_mul_val   (o_mul_val),
    .i_mul_rdy   (i_mul_rdy),
    .o_mul_dat_a (o_mul_dat_a),
    .o_mul_dat_b (o_mul_dat_b),
    .i_mul_val   (i_mul_val),
    .o_mul_rdy   (o_mul_rdy),
    .i_mul_dat   (i_mul_dat)
  );

  always #5 i_clk = ~i_clk;

  int n_run  = 0;
  int n_fail = 0;

  // Single comparison point: count, and report any mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Controls written by the main sequence, read by the multiplier model
  int              stall_n   = 0;
  int              drop_idx  = -1;
  int              job_seq   = 0;
  bit              inj_aa    = 1'b0;
  logic [BITS-1:0] job_x     = '0;
  // Multiplier model state (written only by the model)
  int              hs_cnt    = 0;
  int              delivered = 0;
  int              seen_seq  = 0;
  int              res_idx   = 0;
  int              stall_ctr = 0;
  int              dly       = 0;
  bit              pend      = 1'b0;
  bit              was_stall = 1'b0;
  logic [BITS-1:0] exp_op    = '0;
  logic [BITS-1:0] pres      = '0;
  logic [BITS-1:0] last_a    = '0;

  // Multiplier model: acts 2ns after each rising edge on settled DUT outputs
  initial begin
    i_mul_rdy = 1'b1;
    i_mul_val = 1'b0;
    i_mul_dat = '0;
    forever begin
      @(posedge i_clk);
      #2;
      if (job_seq != seen_seq) begin
        seen_seq = job_seq;
        exp_op   = job_x;
        res_idx  = 0;
      end
      i_mul_val = 1'b0;
      if (pend) begin
        dly--;
        if (dly == 0) begin
          pend = 1'b0;
          if (res_idx != drop_idx) begin
            i_mul_val = 1'b1;
            i_mul_dat = inj_aa ? BITS'(16'h00AA) : pres;
            exp_op    = pres;
          end
          res_idx++;
          delivered++;
        end
      end
      if (o_mul_val === 1'b1) begin
        if (was_stall) check("op_stable", 32'(o_mul_dat_a), 32'(last_a));
        if (stall_ctr < stall_n) begin
          i_mul_rdy = 1'b0;
          stall_ctr++;
          was_stall = 1'b1;
          last_a    = o_mul_dat_a;
        end else begin
          i_mul_rdy = 1'b1;
          stall_ctr = 0;
          was_stall = 1'b0;
          check("op_a_eq_b", 32'(o_mul_dat_b), 32'(o_mul_dat_a));
          check("op_val", 32'(o_mul_dat_a), 32'(exp_op));
          pend = 1'b1;
          dly  = LAT;
          pres = BITS'((longint'(o_mul_dat_a) * longint'(o_mul_dat_a)) % MODV);
          hs_cnt++;
        end
      end else begin
        i_mul_rdy = 1'b1;
        stall_ctr = 0;
        was_stall = 1'b0;
      end
    end
  end

  task automatic start_job(input string tag, input logic [BITS-1:0] x, input logic [CNT_W-1:0] t);
    check({tag, "_rdy_in"}, 32'(o_rdy), 32'd1);
    i_val  = 1'b1;
    i_dat  = x;
    i_iter = t;
    job_x  = x;
    job_seq++;
    @(negedge i_clk);
    i_val  = 1'b0;
  endtask

  // Cycles from request acceptance until o_val is seen (bounded)
  task automatic wait_val(output int k);
    k = 1;
    while (o_val !== 1'b1 && k < 400) begin
      @(negedge i_clk);
      k++;
    end
  endtask

  task automatic release_done(input string tag);
    i_rdy = 1'b1;
    @(negedge i_clk);
    i_rdy = 1'b0;
    check({tag, "_rdy_after"}, 32'(o_rdy), 32'd1);
    check({tag, "_val_after"}, 32'(o_val), 32'd0);
    check({tag, "_busy_after"}, 32'(o_busy), 32'd0);
  endtask

  task automatic run_job(input string tag, input logic [BITS-1:0] x, input logic [CNT_W-1:0] t,
                         input logic [BITS-1:0] exp_dat, input int exp_lat, input int hold);
    int k;
    int hs0;
    hs0 = hs_cnt;
    start_job(tag, x, t);
    wait_val(k);
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_dat"}, 32'(o_dat), 32'(exp_dat));
    check({tag, "_iter"}, 32'(o_iter_cnt), 32'(t));
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_rdy_done"}, 32'(o_rdy), 32'd0);
    check({tag, "_busy_done"}, 32'(o_busy), 32'd1);
    check({tag, "_handshakes"}, 32'(hs_cnt - hs0), 32'(t));
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      check({tag, "_hold_val"}, 32'(o_val), 32'd1);
      check({tag, "_hold_dat"}, 32'(o_dat), 32'(exp_dat));
      check({tag, "_hold_iter"}, 32'(o_iter_cnt), 32'(t));
      check({tag, "_hold_err"}, 32'(o_err), 32'd0);
      check({tag, "_hold_rdy"}, 32'(o_rdy), 32'd0);
    end
    release_done(tag);
  endtask

  initial begin
    int k;
    int d0;
    int hs0;
    i_rst  = 1'b1;
    i_val  = 1'b0;
    i_dat  = '0;
    i_iter = '0;
    i_rdy  = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_rdy", 32'(o_rdy), 32'd1);
    check("rst_val", 32'(o_val), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_iter", 32'(o_iter_cnt), 32'd0);
    check("rst_dat", 32'(o_dat), 32'd0);
    check("rst_mul_val", 32'(o_mul_val), 32'd0);
    check("rst_mul_rdy", 32'(o_mul_rdy), 32'd0);

    // T=0 returns x one cycle after accept, no multiplier traffic
    run_job("t0", 16'd2, 4'd0, 16'd2, 1, 0);
    // 2^(2^3) mod 251 = 5, latency 1+3*8
    run_job("t3", 16'd2, 4'd3, 16'd5, 25, 0);
    // Three stall cycles per issue: 2^(2^4) mod 251 = 25, latency 1+4*11
    stall_n = 3;
    run_job("stall", 16'd2, 4'd4, 16'd25, 45, 0);
    stall_n = 0;
    // Downstream backpressure for 5 cycles: 3^2 = 9
    run_job("hold", 16'd3, 4'd1, 16'd9, 9, 5);
    // Largest count for CNT_W=4: 2^(2^15) mod 251 = 2^18 mod 251 = 100
    run_job("tmax", 16'd2, 4'd15, 16'd100, 121, 0);

    // Second result of a T=3 job never arrives
    drop_idx = 1;
    hs0 = hs_cnt;
`ifdef VDF_SQ_SCHED_TIMEOUT_EN
    start_job("tmo", 16'd2, 4'd3);
    wait_val(k);
    check("tmo_lat", 32'(k), 32'd26);
    check("tmo_err", 32'(o_err), 32'd1);
    check("tmo_iter", 32'(o_iter_cnt), 32'd1);
    check("tmo_dat", 32'(o_dat), 32'd4);
    check("tmo_handshakes", 32'(hs_cnt - hs0), 32'd2);
    release_done("tmo");
`else
    start_job("stuck", 16'd2, 4'd3);
    repeat (40) @(negedge i_clk);
    check("stuck_val", 32'(o_val), 32'd0);
    check("stuck_err", 32'(o_err), 32'd0);
    check("stuck_mul_rdy", 32'(o_mul_rdy), 32'd1);
    check("stuck_iter", 32'(o_iter_cnt), 32'd1);
    check("stuck_handshakes", 32'(hs_cnt - hs0), 32'd2);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("stuck_rst_rdy", 32'(o_rdy), 32'd1);
    check("stuck_rst_busy", 32'(o_busy), 32'd0);
`endif
    drop_idx = -1;

    // Reset while a squaring is in flight; the late result carries 0xAA
    start_job("rstw", 16'd2, 4'd3);
    k = 0;
    while (o_mul_rdy !== 1'b1 && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    check("rstw_in_wait", 32'(o_mul_rdy), 32'd1);
    d0     = delivered;
    inj_aa = 1'b1;
    i_rst  = 1'b1;
    @(negedge i_clk);
    i_rst  = 1'b0;
    check("rstw_rdy", 32'(o_rdy), 32'd1);
    check("rstw_busy", 32'(o_busy), 32'd0);
    check("rstw_iter", 32'(o_iter_cnt), 32'd0);
    check("rstw_mul_rdy", 32'(o_mul_rdy), 32'd0);
    check("rstw_mul_val", 32'(o_mul_val), 32'd0);
    k = 0;
    while (delivered == d0 && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    check("rstw_stale_sent", 32'(delivered - d0), 32'd1);
    @(negedge i_clk);
    inj_aa = 1'b0;
    check("rstw_stale_val", 32'(o_val), 32'd0);
    check("rstw_stale_rdy", 32'(o_rdy), 32'd1);
    check("rstw_stale_dat", 32'(o_dat), 32'd0);
    check("rstw_stale_reg", 32'(o_mul_dat_a), 32'd0);
    run_job("after_rst", 16'd3, 4'd1, 16'd9, 9, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/vdf_square_sched.md
Name: vdf_square_sched

Overview:
- Sequencing controller for the pipelined modular multiplier.
- Accepts a start value x and an iteration count T, then computes x^(2^T) mod MODULUS by issuing T back-to-back squarings.
- Each squaring result is fed back as the next operand. The final value is returned on a valid/ready output.
- Sits between the VDF top-level request interface and one multiplier instance; owns that multiplier's input and output handshakes.

Parameters:
- BITS, 256: operand/result width; must match the multiplier's BITS.
- CNT_W, 32: width of the iteration count and the progress counter.
- TIMEOUT, 64: maximum cycles in WAIT before abort. Used only with VDF_SQ_SCHED_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_val  in  1  request valid.
- o_rdy  out  1  request ready; high only in IDLE.
- i_dat  in  BITS  start value x.
- i_iter  in  CNT_W  number of squarings T.
- o_val  out  1  result valid.
- i_rdy  in  1  result ready from downstream.
- o_dat  out  BITS  result.
- o_err  out  1  result aborted by timeout; qualified by o_val.
- o_iter_cnt  out  CNT_W  squarings completed for the current job.
- o_busy  out  1  high in any state other than IDLE.
- o_mul_val  out  1  operand valid to multiplier.
- i_mul_rdy  in  1  multiplier accepts operands.
- o_mul_dat_a  out  BITS  operand A.
- o_mul_dat_b  out  BITS  operand B; always equals o_mul_dat_a.
- i_mul_val  in  1  multiplier result valid.
- o_mul_rdy  out  1  result ready to multiplier; high only in WAIT.
- i_mul_dat  in  BITS  multiplier result.

Behaviour:
- Reset values: state IDLE; o_val=0, o_err=0, o_busy=0, o_mul_val=0, o_mul_rdy=0, o_iter_cnt=0, o_dat=0, internal value register=0, remaining count=0. o_rdy=1 in the first cycle after reset is released.
- States: IDLE, ISSUE, WAIT, DONE. All outputs are decoded from registered state; there is no combinational path from any input to any output.
- IDLE:
  - o_rdy=1.
  - On i_val & o_rdy: val_r<=i_dat, rem<=i_iter, o_iter_cnt<=0, o_err<=0.
  - If i_iter==0 go to DONE; otherwise go to ISSUE.
- ISSUE:
  - o_mul_val=1, o_mul_dat_a=o_mul_dat_b=val_r.
  - On i_mul_rdy: rem<=rem-1, go to WAIT.
  - If i_mul_rdy is low, hold state with operands stable.
- WAIT:
  - o_mul_rdy=1.
  - On i_mul_val: val_r<=i_mul_dat, o_iter_cnt<=o_iter_cnt+1.
  - Then go to DONE if rem==0, otherwise go to ISSUE.
- DONE:
  - o_val=1, o_dat=val_r.
  - On i_rdy go to IDLE.
  - o_dat, o_err and o_iter_cnt are stable while o_val=1 and i_rdy=0.
- Only one squaring is ever in flight. i_mul_val outside WAIT is ignored and val_r is not modified.
- Latency: let request accept be cycle c0, and L be the cycles from the issue handshake to i_mul_val (L=7 for the standard multiplier). With i_mul_rdy held high, o_val rises at cycle c0+1+T*(L+1). For T=0, o_val rises at c0+1 and o_dat=x.
- Width rules:
  - rem and o_iter_cnt are CNT_W bits and never wrap for legal T ≤ 2^CNT_W-1.
  - T=2^CNT_W-1 must complete correctly.
- Reduction: the block assumes i_mul_dat < MODULUS and performs no reduction itself.
- Reset mid-operation:
  - From any state, i_rst returns the block to IDLE and all outputs to reset values in the next cycle.
  - The in-flight multiplier result is later ignored, because o_mul_rdy=0 outside WAIT.
  - The integrator also resets the multiplier with the same i_rst.
- Simultaneous events: in DONE, i_val is not accepted in the same cycle as i_rdy, because o_rdy=0 in DONE. The minimum gap between jobs is one IDLE cycle.

Optional Feature:
- Macro VDF_SQ_SCHED_TIMEOUT_EN.
- Enabled:
  - A counter starts at 0 on entry to WAIT and increments every cycle in WAIT.
  - If it reaches TIMEOUT without i_mul_val, go to DONE with o_err=1. o_dat then holds the last completed value and o_iter_cnt the completed count.
- Disabled:
  - No counter is built; o_err is tied to 0.
  - WAIT persists indefinitely until i_mul_val.

Test Plan:
1. Multiplier model with MODULUS=251, L=7, i_dat=2, i_iter=0 -> o_val at c0+1, o_dat=2, o_iter_cnt=0, no o_mul_val pulse.
2. Same model, i_dat=2, i_iter=3 -> o_dat=5 (2^8 mod 251) at c0+25; o_iter_cnt=3; exactly 3 operand handshakes with A=B.
3. i_dat=2, i_iter=4, i_mul_rdy low for 3 cycles on each issue -> o_dat=25 at c0+1+4*(8+3)=c0+45; operands stable while stalled.
4. Job completes and i_rdy is held low for 5 cycles -> o_val stays 1 with o_dat, o_err and o_iter_cnt unchanged, and o_rdy=0; after i_rdy=1, o_rdy=1 on the next cycle.
5. i_rst pulsed during WAIT, then a late i_mul_val=1 with i_mul_dat=0xAA -> after reset o_rdy=1 and o_busy=0. A new job with i_dat=3, i_iter=1 returns 9, unaffected by the stale result.
6. With VDF_SQ_SCHED_TIMEOUT_EN and TIMEOUT=16, the model drops the second result of i_iter=3 -> o_val with o_err=1 exactly 16 cycles after entering WAIT, o_iter_cnt=1, o_dat=4.
